decode_hazard_ctrl: RTL and testbench
=====================================

Name: decode_hazard_ctrl

Overview:
- Parametrised decode-stage control unit; generalises the combinational opcode decoder.
- Decodes the 5-bit opcode into read enables, branch/jump flags and an illegal flag.
- Adds a shift-register scoreboard of in-flight writes, RAW stall generation (with or without forwarding), control-transfer bubble counting and sticky halt.
- Sits between fetch and register read; `issue` tells downstream that the decoded instruction advances.

Parameters:
- AW, 3, register-specifier width (2^AW architectural registers).
- PIPE_DEPTH, 3, number of post-decode stages tracked (entry 0 = EX ... entry PIPE_DEPTH-1 = WB); range 1..8.
- FORWARD, 0, 0 = stall on any in-flight match; 1 = full forwarding, stall only on load-use in entry 0.
- CTRL_BUBBLES, 1, forced stall cycles after issuing a branch or jump; range 0..7.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode slot holds a valid instruction.
- opcode  in  5  instruction[15:11].
- rs  in  AW  first source register.
- rt  in  AW  second source register.
- wr_en  in  1  instruction writes a register (decoded elsewhere).
- wr_reg  in  AW  destination register.
- flush  in  1  redirect from a later stage.
- read_en1  out  1  rs is read.
- read_en2  out  1  rt is read.
- branch  out  1  conditional branch (011xx).
- jump  out  1  J/JR/JAL/JALR (001xx).
- illegal  out  1  opcode not in decode table.
- stall  out  1  hold fetch/decode this cycle.
- issue  out  1  instruction advances this cycle.
- halted  out  1  HALT has issued; sticky.

Behaviour:
- Decode (combinational from opcode; outputs are 0 when id_valid=0):
  - read_en1=1, read_en2=0: immediate ALU 010xx/101xx, LD 10001, BTR 11001, SLBI 10010, JR 00101, JALR 00111, branches 011xx.
  - read_en1=1, read_en2=1: ST 10000, STU 10011, 1101x, 111xx.
  - read_en1=read_en2=0: HALT 00000, NOP 00001, LBI 11000, J 00100, JAL 00110.
  - Any other opcode: illegal=1, all other decode outputs 0; treated as NOP for issue.
- Scoreboard: PIPE_DEPTH entries, each {v, reg[AW-1:0], ld}.
  - Every clock: entry0 <= issue ? {wr_en, wr_reg, opcode==10001} : 0; entry i <= entry i-1.
  - Oldest entry drops off; no downstream back-pressure.
- match(r) = OR over i of (v_i & reg_i==r & (FORWARD==0 | (i==0 & ld_0))).
- hazard = (read_en1 & match(rs)) | (read_en2 & match(rt)).
- Bubble counter (3 bits): loaded with CTRL_BUBBLES when a branch or jump issues; otherwise decrements while nonzero.
- stall = id_valid & (hazard | bubble_cnt!=0 | halted).
- issue = id_valid & ~stall & ~flush.
- Halt: issue of opcode 00000 sets halted=1 at the next edge. Only rst_n clears it. While halted, issue=0.
- Flush:
  - Clears all entry valid bits and bubble_cnt at the next edge.
  - Forces issue=0 in the same cycle; a HALT present during flush does not set halted.
  - Does not clear halted.
  - Flush has priority over the counter load and the entry0 write.
- Reset (rst_n low, async): all entries invalid, bubble_cnt=0, halted=0, so stall=0 and issue=id_valid (subject to flush). Decode outputs follow inputs.
- Reset mid-stall: the stall drops immediately and asynchronously.

Test Plan:
- PIPE_DEPTH=3, FORWARD=0: ADD r3 issues cycle N, then SUB reading r3 → stall=1 in N+1..N+3, issue=1 in N+4.
- FORWARD=1: LD r2 issues cycle N, then ADD reading r2 → exactly one stall (N+1), issue at N+2. ADDI r2 followed by ADD r2 → zero stalls.
- CTRL_BUBBLES=2: BEQZ issues cycle N, then NOP → stall at N+1 and N+2, issue at N+3. CTRL_BUBBLES=0 → no stall.
- FORWARD=0, SUB waiting on r3 in entry 1, flush=1 at N+2 → issue=0 at N+2, stall=0 and issue=1 at N+3.
- HALT issues → halted=1 next cycle; stall=1 and issue=0 for all later id_valid; rst_n pulse low clears halted asynchronously.
- opcode 00010 with id_valid=1 → illegal=1, read_en1/read_en2/branch/jump=0, issue=1; the entry written has v=wr_en and ld=0.

Source files
------------

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage control: opcode decode, in-flight write scoreboard, RAW stall,
// control-transfer bubbles and sticky halt.
module decode_hazard_ctrl #(
    parameter int AW           = 3,
    parameter int PIPE_DEPTH   = 3,
    parameter int FORWARD      = 0,
    parameter int CTRL_BUBBLES = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [4:0]    opcode,
    input  logic [AW-1:0] rs,
    input  logic [AW-1:0] rt,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_reg,
    input  logic          flush,
    output logic          read_en1,
    output logic          read_en2,
    output logic          branch,
    output logic          jump,
    output logic          illegal,
    output logic          stall,
    output logic          issue,
    output logic          halted
);

    localparam logic [4:0] OP_HALT     = 5'b00000;
    localparam logic [4:0] OP_LD       = 5'b10001;
    localparam logic [2:0] BUBBLE_LOAD = 3'(CTRL_BUBBLES);

    logic                dec_re1;
    logic                dec_re2;
    logic                dec_ill;
    logic [PIPE_DEPTH-1:0] sb_v;
    logic [AW-1:0]       sb_reg [PIPE_DEPTH];
    logic                sb_ld0;
    logic [2:0]          bubble_cnt;
    logic                match_rs;
    logic                match_rt;
    logic                hazard;

    always_comb begin
        dec_re1 = 1'b0;
        dec_re2 = 1'b0;
        dec_ill = 1'b0;
        casez (opcode)
            5'b010??, 5'b101??, 5'b10001, 5'b11001,
            5'b10010, 5'b00101, 5'b00111, 5'b011??: dec_re1 = 1'b1;
            5'b10000, 5'b10011, 5'b1101?, 5'b111??: begin
                dec_re1 = 1'b1;
                dec_re2 = 1'b1;
            end
            5'b00000, 5'b00001, 5'b11000, 5'b00100, 5'b00110: ;
            default: dec_ill = 1'b1;
        endcase
    end

    assign read_en1 = id_valid & dec_re1;
    assign read_en2 = id_valid & dec_re2;
    assign illegal  = id_valid & dec_ill;
    assign branch   = id_valid & (opcode[4:2] == 3'b011);
    assign jump     = id_valid & (opcode[4:2] == 3'b001);

    // With forwarding only a load still in EX (entry 0) cannot supply its result.
    always_comb begin
        match_rs = 1'b0;
        match_rt = 1'b0;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            if (sb_v[i] && (FORWARD == 0 || (i == 0 && sb_ld0))) begin
                if (sb_reg[i] == rs) match_rs = 1'b1;
                if (sb_reg[i] == rt) match_rt = 1'b1;
            end
        end
    end

    assign hazard = (read_en1 & match_rs) | (read_en2 & match_rt);

    // Handshake: id_valid offers the decoded instruction; it is consumed only in
    // a cycle where issue=1 (no stall, no flush), otherwise fetch must hold it.
    assign stall = id_valid & (hazard | (bubble_cnt != 3'd0) | halted);
    assign issue = id_valid & ~stall & ~flush;

    // Entries shift every cycle with no back-pressure; the oldest falls off the end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_v   <= '0;
            sb_ld0 <= 1'b0;
            for (int i = 0; i < PIPE_DEPTH; i++) sb_reg[i] <= '0;
        end else begin
            sb_v[0]   <= issue & wr_en;
            sb_reg[0] <= wr_reg;
            sb_ld0    <= issue & (opcode == OP_LD);
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                sb_v[i]   <= sb_v[i-1] & ~flush;
                sb_reg[i] <= sb_reg[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= 3'd0;
        end else if (flush) begin
            bubble_cnt <= 3'd0;
        end else if (issue && (branch || jump)) begin
            bubble_cnt <= BUBBLE_LOAD;
        end else if (bubble_cnt != 3'd0) begin
            bubble_cnt <= bubble_cnt - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted <= 1'b0;
        end else if (issue && opcode == OP_HALT) begin
            halted <= 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Bench for decode_hazard_ctrl: three parameter sets share one stimulus stream,
// each checked against its own in-flight-write model.
module tb_decode_hazard_ctrl;

    localparam int NCFG = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] opcode;
    logic [2:0] rs;
    logic [2:0] rt;
    logic       wr_en;
    logic [2:0] wr_reg;
    logic       flush;

    logic [NCFG-1:0] o_re1, o_re2, o_br, o_jmp, o_ill, o_stall, o_issue, o_halt;

    int cfg_depth [NCFG] = '{3, 3, 5};
    int cfg_fwd   [NCFG] = '{0, 1, 0};
    int cfg_cb    [NCFG] = '{1, 2, 0};

    always #5 clk = ~clk;

    decode_hazard_ctrl #(.AW(3), .PIPE_DEPTH(3), .FORWARD(0), .CTRL_BUBBLES(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(opcode), .rs(rs), .rt(rt),
        .wr_en(wr_en), .wr_reg(wr_reg), .flush(flush), .read_en1(o_re1[0]), .read_en2(o_re2[0]),
        .branch(o_br[0]), .jump(o_jmp[0]), .illegal(o_ill[0]), .stall(o_stall[0]),
        .issue(o_issue[0]), .halted(o_halt[0]));

    decode_hazard_ctrl #(.AW(3), .PIPE_DEPTH(3), .FORWARD(1), .CTRL_BUBBLES(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(opcode), .rs(rs), .rt(rt),
        .wr_en(wr_en), .wr_reg(wr_reg), .flush(flush), .read_en1(o_re1[1]), .read_en2(o_re2[1]),
        .branch(o_br[1]), .jump(o_jmp[1]), .illegal(o_ill[1]), .stall(o_stall[1]),
        .issue(o_issue[1]), .halted(o_halt[1]));

    decode_hazard_ctrl #(.AW(3), .PIPE_DEPTH(5), .FORWARD(0), .CTRL_BUBBLES(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(opcode), .rs(rs), .rt(rt),
        .wr_en(wr_en), .wr_reg(wr_reg), .flush(flush), .read_en1(o_re1[2]), .read_en2(o_re2[2]),
        .branch(o_br[2]), .jump(o_jmp[2]), .illegal(o_ill[2]), .stall(o_stall[2]),
        .issue(o_issue[2]), .halted(o_halt[2]));

    // Reference model: a list of issued writes tagged with their issue cycle.
    typedef struct {
        int cfg;
        int r;
        int c;
        bit ld;
    } wr_t;

    wr_t wq[$];
    int  cyc = 0;
    int  last_ctrl [NCFG];
    bit  m_halt    [NCFG];
    bit  e_re1, e_re2, e_br, e_jmp, e_ill;
    bit  e_stall [NCFG];
    bit  e_issue [NCFG];
    int  checks   = 0;
    int  failures = 0;

    typedef struct {
        logic       v;
        logic [4:0] op;
        logic       fl;
        logic       re1, re2, br, jmp, ill, iss;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%b expected=%b (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic void dec_ref(input logic [4:0] op, output bit r1, output bit r2,
                                    output bit ill);
        r1 = 0; r2 = 0; ill = 0;
        if (op inside {5'd0, 5'd1, 5'b11000, 5'b00100, 5'b00110}) begin
        end else if (op[4:2] inside {3'b010, 3'b101, 3'b011} ||
                     op inside {5'b10001, 5'b11001, 5'b10010, 5'b00101, 5'b00111}) begin
            r1 = 1;
        end else if (op inside {5'b10000, 5'b10011} || op[4:1] == 4'b1101 ||
                     op[4:2] == 3'b111) begin
            r1 = 1; r2 = 1;
        end else begin
            ill = 1;
        end
    endfunction

    task automatic model_reset();
        wq.delete();
        for (int k = 0; k < NCFG; k++) begin
            last_ctrl[k] = -1000;
            m_halt[k]    = 0;
        end
    endtask

    task automatic predict();
        bit r1, r2, ill, hz, bub;
        int age;
        dec_ref(opcode, r1, r2, ill);
        e_re1 = id_valid && r1;
        e_re2 = id_valid && r2;
        e_ill = id_valid && ill;
        e_br  = id_valid && opcode[4:2] == 3'b011;
        e_jmp = id_valid && opcode[4:2] == 3'b001;
        for (int k = 0; k < NCFG; k++) begin
            hz = 0;
            foreach (wq[j]) begin
                age = cyc - wq[j].c;
                if (wq[j].cfg == k && age >= 1 && age <= cfg_depth[k] &&
                    (cfg_fwd[k] == 0 || (age == 1 && wq[j].ld))) begin
                    if (e_re1 && wq[j].r == int'(rs)) hz = 1;
                    if (e_re2 && wq[j].r == int'(rt)) hz = 1;
                end
            end
            bub = (cyc - last_ctrl[k]) <= cfg_cb[k];
            e_stall[k] = id_valid && (hz || bub || m_halt[k]);
            e_issue[k] = id_valid && !e_stall[k] && !flush;
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < NCFG; k++) begin
            chk($sformatf("c%0d_read_en1", k), o_re1[k], e_re1);
            chk($sformatf("c%0d_read_en2", k), o_re2[k], e_re2);
            chk($sformatf("c%0d_branch", k), o_br[k], e_br);
            chk($sformatf("c%0d_jump", k), o_jmp[k], e_jmp);
            chk($sformatf("c%0d_illegal", k), o_ill[k], e_ill);
            chk($sformatf("c%0d_stall", k), o_stall[k], e_stall[k]);
            chk($sformatf("c%0d_issue", k), o_issue[k], e_issue[k]);
            chk($sformatf("c%0d_halted", k), o_halt[k], m_halt[k]);
        end
    endtask

    task automatic update();
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int k = 0; k < NCFG; k++) begin
                if (e_issue[k]) begin
                    if (wr_en) wq.push_back('{k, int'(wr_reg), cyc, opcode == 5'b10001});
                    if (e_br || e_jmp) last_ctrl[k] = cyc;
                    if (opcode == 5'd0) m_halt[k] = 1;
                end
                if (flush) begin
                    for (int j = wq.size() - 1; j >= 0; j--)
                        if (wq[j].cfg == k) wq.delete(j);
                    last_ctrl[k] = -1000;
                end
            end
        end
        cyc++;
        for (int j = wq.size() - 1; j >= 0; j--)
            if (cyc - wq[j].c > 8) wq.delete(j);
    endtask

    task automatic sample();
        @(negedge clk);
        predict();
        compare_all();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        update();
    endtask

    task automatic set_in(input logic v, input logic [4:0] op, input logic [2:0] a,
                          input logic [2:0] b, input logic we, input logic [2:0] wr,
                          input logic fl);
        id_valid = v; opcode = op; rs = a; rt = b; wr_en = we; wr_reg = wr; flush = fl;
    endtask

    task automatic do_reset();
        set_in(0, 5'd1, 0, 0, 0, 0, 0);
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    initial begin
        tbl[0]  = '{1, 5'b00000, 0, 0, 0, 0, 0, 0, 1};
        tbl[1]  = '{1, 5'b00001, 0, 0, 0, 0, 0, 0, 1};
        tbl[2]  = '{1, 5'b00010, 0, 0, 0, 0, 0, 1, 1};
        tbl[3]  = '{1, 5'b00011, 0, 0, 0, 0, 0, 1, 1};
        tbl[4]  = '{1, 5'b00100, 0, 0, 0, 0, 1, 0, 1};
        tbl[5]  = '{1, 5'b00101, 0, 1, 0, 0, 1, 0, 1};
        tbl[6]  = '{1, 5'b00111, 0, 1, 0, 0, 1, 0, 1};
        tbl[7]  = '{1, 5'b01000, 0, 1, 0, 0, 0, 0, 1};
        tbl[8]  = '{1, 5'b01110, 0, 1, 0, 1, 0, 0, 1};
        tbl[9]  = '{1, 5'b10000, 0, 1, 1, 0, 0, 0, 1};
        tbl[10] = '{1, 5'b10001, 0, 1, 0, 0, 0, 0, 1};
        tbl[11] = '{1, 5'b10010, 0, 1, 0, 0, 0, 0, 1};
        tbl[12] = '{1, 5'b11000, 0, 0, 0, 0, 0, 0, 1};
        tbl[13] = '{1, 5'b11010, 0, 1, 1, 0, 0, 0, 1};
        tbl[14] = '{1, 5'b11111, 0, 1, 1, 0, 0, 0, 1};
        tbl[15] = '{1, 5'b10101, 0, 1, 0, 0, 0, 0, 1};
        tbl[16] = '{0, 5'b11011, 0, 0, 0, 0, 0, 0, 0};
        tbl[17] = '{1, 5'b11011, 1, 1, 1, 0, 0, 0, 0};

        // Decode table applied while held in reset: no stall, issue follows id_valid.
        rst_n = 0;
        model_reset();
        set_in(0, 5'd1, 0, 0, 0, 0, 0);
        for (int n = 0; n < 18; n++) begin
            set_in(tbl[n].v, tbl[n].op, 3'd1, 3'd2, 1, 3'd3, tbl[n].fl);
            #2;
            for (int k = 0; k < NCFG; k++) begin
                chk($sformatf("tbl%0d_c%0d_re1", n, k), o_re1[k], tbl[n].re1);
                chk($sformatf("tbl%0d_c%0d_re2", n, k), o_re2[k], tbl[n].re2);
                chk($sformatf("tbl%0d_c%0d_br", n, k), o_br[k], tbl[n].br);
                chk($sformatf("tbl%0d_c%0d_jmp", n, k), o_jmp[k], tbl[n].jmp);
                chk($sformatf("tbl%0d_c%0d_ill", n, k), o_ill[k], tbl[n].ill);
                chk($sformatf("tbl%0d_c%0d_iss", n, k), o_issue[k], tbl[n].iss);
                chk($sformatf("tbl%0d_c%0d_stall", n, k), o_stall[k], 1'b0);
                chk($sformatf("tbl%0d_c%0d_halt", n, k), o_halt[k], 1'b0);
            end
        end

        // RAW without forwarding: stall three cycles, issue on the fourth.
        do_reset();
        set_in(1, 5'b11011, 1, 2, 1, 3, 0);
        sample(); chk("raw_add_issue", o_issue[0], 1); tick();
        set_in(1, 5'b11011, 3, 4, 1, 5, 0);
        for (int n = 1; n <= 3; n++) begin
            sample(); chk("raw_stall", o_stall[0], 1); chk("raw_hold", o_issue[0], 0); tick();
        end
        sample(); chk("raw_release", o_issue[0], 1); chk("raw_release_stall", o_stall[0], 0); tick();

        // Forwarding: load-use costs one cycle, ALU-use costs none.
        do_reset();
        set_in(1, 5'b10001, 0, 0, 1, 2, 0);
        sample(); chk("ld_issue", o_issue[1], 1); tick();
        set_in(1, 5'b11011, 2, 1, 1, 4, 0);
        sample(); chk("ld_use_stall", o_stall[1], 1); tick();
        sample(); chk("ld_use_issue", o_issue[1], 1); chk("ld_use_nostall", o_stall[1], 0); tick();
        do_reset();
        set_in(1, 5'b01000, 0, 0, 1, 2, 0);
        sample(); tick();
        set_in(1, 5'b11011, 2, 1, 1, 4, 0);
        sample(); chk("fwd_alu_nostall", o_stall[1], 0); chk("fwd_alu_issue", o_issue[1], 1); tick();

        // Branch bubbles: 2 on dut1, 1 on dut0, none on dut2.
        do_reset();
        set_in(1, 5'b01100, 1, 0, 0, 0, 0);
        sample(); chk("beqz_issue", o_issue[1], 1); tick();
        set_in(1, 5'b00001, 0, 0, 0, 0, 0);
        sample(); chk("bub2_stall_a", o_stall[1], 1); chk("bub1_stall", o_stall[0], 1);
        chk("bub0_issue", o_issue[2], 1); tick();
        sample(); chk("bub2_stall_b", o_stall[1], 1); chk("bub1_issue", o_issue[0], 1); tick();
        sample(); chk("bub2_issue", o_issue[1], 1); tick();

        // Flush while a RAW stall is pending.
        do_reset();
        set_in(1, 5'b11011, 1, 2, 1, 3, 0);
        sample(); tick();
        set_in(1, 5'b11011, 3, 4, 1, 5, 0);
        sample(); chk("fl_pre_stall", o_stall[0], 1); tick();
        flush = 1;
        sample(); chk("fl_issue0", o_issue[0], 0); tick();
        flush = 0;
        sample(); chk("fl_after_stall", o_stall[0], 0); chk("fl_after_issue", o_issue[0], 1); tick();

        // Halt is sticky through flush, cleared asynchronously by reset.
        do_reset();
        set_in(1, 5'b00000, 0, 0, 0, 0, 0);
        sample(); chk("halt_issue", o_issue[0], 1); tick();
        set_in(1, 5'b00001, 0, 0, 0, 0, 0);
        for (int n = 0; n < 3; n++) begin
            flush = (n == 1);
            sample(); chk("halted_set", o_halt[0], 1); chk("halted_stall", o_stall[0], 1);
            chk("halted_noissue", o_issue[0], 0); tick();
        end
        flush = 0;
        sample();
        #1 rst_n = 0;
        #1;
        chk("async_rst_halted", o_halt[0], 0);
        chk("async_rst_stall", o_stall[0], 0);
        chk("async_rst_issue", o_issue[0], 1);
        model_reset();
        tick();
        rst_n = 1;
        do_reset();
        set_in(1, 5'b00000, 0, 0, 0, 0, 1);
        sample(); chk("flush_halt_noissue", o_issue[0], 0); tick();
        set_in(1, 5'b00001, 0, 0, 0, 0, 0);
        sample(); chk("flush_halt_nohalt", o_halt[0], 0); chk("flush_halt_next", o_issue[0], 1); tick();

        // Illegal opcode issues as a NOP but still records its write (ld=0).
        do_reset();
        set_in(1, 5'b00010, 0, 0, 1, 6, 0);
        sample(); chk("ill_flag", o_ill[0], 1); chk("ill_issue", o_issue[0], 1); tick();
        set_in(1, 5'b01000, 6, 0, 1, 1, 0);
        sample(); chk("ill_wr_stall", o_stall[0], 1); chk("ill_ld0_nostall", o_stall[1], 0); tick();

        // Randomized traffic against the model.
        for (int b = 0; b < 4; b++) begin
            do_reset();
            for (int n = 0; n < 150; n++) begin
                logic [4:0] op;
                op = 5'($urandom_range(0, 31));
                if (op == 5'd0 && $urandom_range(0, 9) != 0) op = 5'd1;
                set_in($urandom_range(0, 9) != 0, op, 3'($urandom_range(0, 7)),
                       3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                       3'($urandom_range(0, 7)), $urandom_range(0, 15) == 0);
                sample();
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
